// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage S1 registers the operands and opcode. Stage S2 registers the result,
// its status flags and out_valid. The block also keeps saturating counts of
// completed results and of completed illegal-opcode results.
module alu_pipe #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // operand-issue side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    // writeback side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_err,
    // statistics
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,   // a + b
        OP_SUB  = 3'b001,   // a - b
        OP_RSB  = 3'b010,   // b - a
        OP_OR   = 3'b011,
        OP_AND  = 3'b100,
        OP_XOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_ILL  = 3'b111    // reserved, reported through out_err
    } op_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Stage S1 state
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;

    // Handshake control
    logic s2_advance;
    logic out_fire;

    // Datapath between S1 and S2
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ab_ext;
    logic [WIDTH:0]   diff_ba_ext;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;
    logic             alu_zero;
    logic             alu_neg;

    // S2 is free to take a new beat when it is empty or its beat leaves now.
    // in_ready depends on out_ready combinationally but never on in_valid,
    // so there is no combinational path from the input side to out_valid.
    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;
    assign out_fire   = out_valid && out_ready;

    // One extra bit on each arithmetic result captures carry-out / borrow.
    // For an unsigned subtraction the extra bit is set exactly when the
    // minuend is smaller than the subtrahend.
    assign sum_ext     = {1'b0, s1_a} + {1'b0, s1_b};
    assign diff_ab_ext = {1'b0, s1_a} - {1'b0, s1_b};
    assign diff_ba_ext = {1'b0, s1_b} - {1'b0, s1_a};
    assign sign_a      = s1_a[WIDTH-1];
    assign sign_b      = s1_b[WIDTH-1];

    // Result and carry/overflow selection for the opcode held in S1.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // opcode path leaves a signal unassigned and infers a latch.
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        alu_err    = 1'b0;
        case (s1_op)
            OP_ADD: begin
                alu_result = sum_ext[WIDTH-1:0];
                alu_carry  = sum_ext[WIDTH];
                alu_ovf    = (sign_a == sign_b) && (sum_ext[WIDTH-1] != sign_a);
            end
            OP_SUB: begin
                alu_result = diff_ab_ext[WIDTH-1:0];
                alu_carry  = diff_ab_ext[WIDTH];
                alu_ovf    = (sign_a != sign_b) && (diff_ab_ext[WIDTH-1] != sign_a);
            end
            OP_RSB: begin
                alu_result = diff_ba_ext[WIDTH-1:0];
                alu_carry  = diff_ba_ext[WIDTH];
                alu_ovf    = (sign_b != sign_a) && (diff_ba_ext[WIDTH-1] != sign_b);
            end
            OP_OR:   alu_result = s1_a | s1_b;
            OP_AND:  alu_result = s1_a & s1_b;
            OP_XOR:  alu_result = s1_a ^ s1_b;
            OP_XNOR: alu_result = ~(s1_a ^ s1_b);
            default: alu_err    = 1'b1;   // OP_ILL: result stays zero
        endcase
    end

    // zero/neg come from the final result, so an illegal op reports zero=1.
    assign alu_zero = (alu_result == '0);
    assign alu_neg  = alu_result[WIDTH-1];

    // Stage S1: capture an operand beat whenever the input side is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so that every
        // register samples its inputs from before the edge, independent of
        // the order in which the always blocks are evaluated.
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= in_a;
                s1_b  <= in_b;
                s1_op <= op_e'(in_op);
            end
        end
    end

    // Stage S2: take the computed beat from S1 when S2 advances; otherwise
    // hold the presented result and flags stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset along with the valid bits
        // because the result and flag outputs must read zero during reset;
        // data registers that never reach an output could skip the reset.
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
            out_zero   <= 1'b0;
            out_neg    <= 1'b0;
            out_err    <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= alu_result;
                out_carry  <= alu_carry;
                out_ovf    <= alu_ovf;
                out_zero   <= alu_zero;
                out_neg    <= alu_neg;
                out_err    <= alu_err;
            end
        end
    end

    // Saturating counters of completed results and completed illegal ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count  <= '0;
            err_count <= '0;
        end else if (out_fire) begin
            if (op_count != CNT_MAX) begin
                op_count <= op_count + CNT_ONE;
            end
            if (out_err && (err_count != CNT_MAX)) begin
                err_count <= err_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe at WIDTH=8, CNT_W=4.
// Expected results come from a plain-arithmetic reference model and a queue
// of in-flight beats; inputs are driven and outputs sampled mid-cycle.
module tb_alu_pipe;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [2:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_carry;
    logic          out_ovf;
    logic          out_zero;
    logic          out_neg;
    logic          out_err;
    logic [CW-1:0] op_count;
    logic [CW-1:0] err_count;

    alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_err    (out_err),
        .op_count   (op_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
        logic       e;
    } beat_t;

    int vectors     = 0;
    int miscompares = 0;

    // Values captured by step() just before the rising edge
    logic    obs_valid;
    logic    obs_in_ready;
    logic    obs_acc;
    logic    obs_fire;
    beat_t   obs_beat;
    logic [CW-1:0] obs_ops;
    logic [CW-1:0] obs_errs;

    // Reference model: integer arithmetic on the opcode definitions.
    function automatic beat_t model(input logic [7:0] a, input logic [7:0] b,
                                    input logic [2:0] op);
        int    ua, ub, sa, sb, r;
        beat_t e;
        ua = int'(a);
        ub = int'(b);
        sa = $signed(a);
        sb = $signed(b);
        e  = '0;
        r  = 0;
        case (op)
            3'd0: begin r = ua + ub; e.c = (r > 255); e.v = (sa + sb > 127) || (sa + sb < -128); end
            3'd1: begin r = ua - ub; e.c = (ua < ub); e.v = (sa - sb > 127) || (sa - sb < -128); end
            3'd2: begin r = ub - ua; e.c = (ub < ua); e.v = (sb - sa > 127) || (sb - sa < -128); end
            3'd3: r = ua | ub;
            3'd4: r = ua & ub;
            3'd5: r = ua ^ ub;
            3'd6: r = ~(ua ^ ub);
            default: begin r = 0; e.e = 1'b1; end
        endcase
        e.r = r[7:0];
        e.z = (e.r == 8'h00);
        e.n = e.r[7];
        return e;
    endfunction

    function automatic int sat(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    // Drive one cycle of inputs at the falling edge, sample, wait a cycle.
    task automatic step(input logic iv, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic ordy);
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        #1;
        obs_valid    = out_valid;
        obs_in_ready = in_ready;
        obs_acc      = iv && in_ready;
        obs_fire     = out_valid && ordy;
        obs_beat     = '{r: out_result, c: out_carry, v: out_ovf, z: out_zero,
                         n: out_neg, e: out_err};
        obs_ops      = op_count;
        obs_errs     = err_count;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        vectors++;
        if ({out_result, out_carry, out_ovf, out_zero, out_neg, out_err} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {out_result, out_carry, out_ovf, out_zero, out_neg, out_err});
        end
        vectors++;
        if ({op_count, err_count} !== 8'h00) begin
            miscompares++; $display("FAIL reset_counters: got %h expected 00", {op_count, err_count});
        end
        @(negedge clk);
    endtask

    // 0xFF + 0x01 wraps to zero; also checks the exact two-cycle latency.
    task automatic test_add_latency();
        beat_t exp;
        exp = '{r: 8'h00, c: 1'b1, v: 1'b0, z: 1'b1, n: 1'b0, e: 1'b0};
        do_reset();
        step(1'b1, 8'hFF, 8'h01, 3'b000, 1'b1);
        vectors++;
        if (obs_acc !== 1'b1) begin miscompares++; $display("FAIL add_accept: got %b expected 1", obs_acc); end
        step(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        vectors++;
        if (obs_valid !== 1'b0) begin miscompares++; $display("FAIL add_early_valid: got %b expected 0", obs_valid); end
        step(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        vectors++;
        if (obs_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid: got %b expected 1", obs_valid); end
        vectors++;
        if (obs_beat !== exp) begin miscompares++; $display("FAIL add_wrap_beat: got %h expected %h", obs_beat, exp); end
    endtask

    // Signed overflow on add, borrow on a-b, and the reversed subtraction.
    task automatic test_arith();
        beat_t exp [3];
        exp[0] = '{r: 8'h80, c: 1'b0, v: 1'b1, z: 1'b0, n: 1'b1, e: 1'b0};
        exp[1] = '{r: 8'hFE, c: 1'b1, v: 1'b0, z: 1'b0, n: 1'b1, e: 1'b0};
        exp[2] = '{r: 8'h02, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0, e: 1'b0};
        do_reset();
        step(1'b1, 8'h7F, 8'h01, 3'b000, 1'b1);
        step(1'b1, 8'h03, 8'h05, 3'b001, 1'b1);
        step(1'b1, 8'h03, 8'h05, 3'b010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
            vectors++;
            if (!obs_valid || obs_beat !== exp[i]) begin
                miscompares++;
                $display("FAIL arith_beat%0d: got valid=%b %h expected valid=1 %h", i, obs_valid, obs_beat, exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        beat_t exp;
        exp = '{r: 8'h00, c: 1'b0, v: 1'b0, z: 1'b1, n: 1'b0, e: 1'b1};
        do_reset();
        step(1'b1, 8'h12, 8'h34, 3'b111, 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        vectors++;
        if (!obs_fire || obs_beat !== exp) begin
            miscompares++;
            $display("FAIL illegal_beat: got fire=%b %h expected fire=1 %h", obs_fire, obs_beat, exp);
        end
        step(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        vectors++;
        if (obs_errs !== 4'd1) begin miscompares++; $display("FAIL illegal_err_count: got %0d expected 1", obs_errs); end
        vectors++;
        if (obs_ops !== 4'd1) begin miscompares++; $display("FAIL illegal_op_count: got %0d expected 1", obs_ops); end
    endtask

    // mode 0: back-to-back input, out_ready 1,0,0 repeating.
    // mode 1: random input gaps and random out_ready.
    task automatic test_stream(input int n, input int mode);
        beat_t      q[$];
        beat_t      held;
        logic       stall_prev;
        logic       iv, ordy;
        logic [7:0] a, b;
        logic [2:0] op;
        int         sent, got, errs, cyc;
        do_reset();
        sent = 0; got = 0; errs = 0; cyc = 0;
        stall_prev = 1'b0;
        held = '0;
        while ((sent < n || q.size() > 0) && cyc < n * 8 + 20) begin
            iv   = (sent < n) && (mode == 0 || $urandom_range(0, 3) != 0);
            ordy = (mode == 0) ? (cyc % 3 == 0) : ($urandom_range(0, 2) != 0);
            a    = 8'($urandom);
            b    = 8'($urandom);
            op   = 3'($urandom_range(0, 7));
            step(iv, a, b, op, ordy);
            vectors++;
            if (obs_in_ready !== ((q.size() < 2) || ordy)) begin
                miscompares++;
                $display("FAIL stream%0d_in_ready: cycle %0d got %b expected %b", mode, cyc, obs_in_ready,
                         (q.size() < 2) || ordy);
            end
            if (stall_prev) begin
                vectors++;
                if (!obs_valid || obs_beat !== held) begin
                    miscompares++;
                    $display("FAIL stream%0d_hold: cycle %0d got valid=%b %h expected valid=1 %h",
                             mode, cyc, obs_valid, obs_beat, held);
                end
            end
            if (obs_valid) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream%0d_spurious: cycle %0d got %h expected no beat", mode, cyc, obs_beat);
                end else if (obs_beat !== q[0]) begin
                    miscompares++;
                    $display("FAIL stream%0d_beat: cycle %0d got %h expected %h", mode, cyc, obs_beat, q[0]);
                end
            end
            if (obs_fire && q.size() > 0) begin
                if (q[0].e) errs++;
                void'(q.pop_front());
                got++;
            end
            if (obs_acc) begin
                q.push_back(model(a, b, op));
                sent++;
            end
            stall_prev = obs_valid && !ordy;
            held       = obs_beat;
            cyc++;
        end
        vectors++;
        if (got != n) begin miscompares++; $display("FAIL stream%0d_count: got %0d beats expected %0d", mode, got, n); end
        step(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        vectors++;
        if (obs_ops !== 4'(sat(n))) begin
            miscompares++; $display("FAIL stream%0d_op_count: got %0d expected %0d", mode, obs_ops, sat(n));
        end
        vectors++;
        if (obs_errs !== 4'(sat(errs))) begin
            miscompares++; $display("FAIL stream%0d_err_count: got %0d expected %0d", mode, obs_errs, sat(errs));
        end
    endtask

    // 20 legal operations into a 4-bit counter: must stop at 15.
    task automatic test_saturation();
        int sent, fires, cyc;
        do_reset();
        sent = 0; fires = 0; cyc = 0;
        while (fires < 20 && cyc < 60) begin
            step(sent < 20, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 6)), 1'b1);
            vectors++;
            if (obs_ops !== 4'(sat(fires))) begin
                miscompares++; $display("FAIL sat_op_count: cycle %0d got %0d expected %0d", cyc, obs_ops, sat(fires));
            end
            if (obs_acc) sent++;
            if (obs_fire) fires++;
            cyc++;
        end
        step(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        vectors++;
        if (fires != 20 || obs_ops !== 4'd15) begin
            miscompares++; $display("FAIL sat_final: got %0d results count %0d expected 20 results count 15", fires, obs_ops);
        end
    endtask

    // Reset with both stages full and output stalled, then a clean restart.
    task automatic test_reset_midflight();
        beat_t exp;
        do_reset();
        step(1'b1, 8'h01, 8'h02, 3'b000, 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        step(1'b1, 8'h10, 8'h20, 3'b000, 1'b0);
        step(1'b1, 8'h30, 8'h40, 3'b101, 1'b0);
        step(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
        vectors++;
        if (obs_in_ready !== 1'b0 || obs_valid !== 1'b1 || obs_ops !== 4'd1) begin
            miscompares++;
            $display("FAIL midflight_full: got in_ready=%b valid=%b ops=%0d expected 0 1 1",
                     obs_in_ready, obs_valid, obs_ops);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || op_count !== 4'd0 || err_count !== 4'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midflight_reset: got valid=%b ops=%0d errs=%0d in_ready=%b expected 0 0 0 1",
                     out_valid, op_count, err_count, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
            vectors++;
            if (obs_valid !== 1'b0) begin miscompares++; $display("FAIL midflight_stale: got valid=%b expected 0", obs_valid); end
        end
        exp = model(8'hC8, 8'h64, 3'b001);
        step(1'b1, 8'hC8, 8'h64, 3'b001, 1'b1);
        vectors++;
        if (obs_acc !== 1'b1) begin miscompares++; $display("FAIL midflight_accept: got %b expected 1", obs_acc); end
        step(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
        vectors++;
        if (!obs_valid || obs_beat !== exp) begin
            miscompares++;
            $display("FAIL midflight_first: got valid=%b %h expected valid=1 %h", obs_valid, obs_beat, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_add_latency();
        test_arith();
        test_illegal();
        test_stream(10, 0);
        test_stream(60, 1);
        test_saturation();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's 64-bit combinational ALU datapath.
- Registers operands and opcode, computes the result with status flags, and presents it through valid/ready handshakes on both sides.
- Sits between an operand-issue stage and a writeback stage; supports full-throughput streaming with backpressure.
- Counts completed operations and illegal-opcode events.

Parameters:
- WIDTH, 64, operand/result width in bits (legal values ≥ 2).
- CNT_W, 16, width of the completed-operation and error counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  opcode.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  result.
- out_carry  output  1  carry/borrow flag.
- out_ovf  output  1  signed overflow flag.
- out_zero  output  1  result == 0.
- out_neg  output  1  result MSB.
- out_err  output  1  illegal opcode for this beat.
- op_count  output  CNT_W  completed-result count, saturating.
- err_count  output  CNT_W  completed illegal-op count, saturating.

Behaviour:
- Reset (async assert, sync-safe deassert): all outputs and both pipeline valid bits are 0, and both counters are 0.
- After reset, in_ready is 1.
- Pipeline structure:
  - Stage S1 holds in_a, in_b and in_op.
  - Stage S2 holds the result, all flags and out_valid.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stall rules:
  - S2 advances when !out_valid || out_ready.
  - S1 advances into S2 when S1 is valid and S2 advances.
  - in_ready = !s1_valid || s2_advance. This is combinational from out_ready; no combinational in_valid→out path is allowed.
- Latency and throughput:
  - Accepted beat appears on out_valid exactly 2 cycles later when out_ready stays high.
  - Throughput is 1 beat/cycle.
- Under backpressure:
  - Held outputs and flags stay stable while out_valid && !out_ready.
  - No beat is dropped or duplicated, and order is preserved.
- Opcodes (arithmetic is modulo 2^WIDTH):
  - 000: a+b. carry = carry-out. ovf = sign(a)==sign(b) && sign(r)!=sign(a).
  - 001: a-b. carry = borrow (1 iff a<b unsigned). ovf = sign(a)!=sign(b) && sign(r)!=sign(a).
  - 010: b-a. Same rules as 001 with operands swapped.
  - 011: a|b.
  - 100: a&b.
  - 101: a^b.
  - 110: ~(a^b).
  - 111: illegal. result = 0, err = 1.
- Flags for logic ops and illegal op: carry = 0, ovf = 0.
- zero and neg are computed from the final result for every opcode, so illegal op gives zero=1.
- Counters:
  - op_count increments on each output transfer.
  - err_count increments on each output transfer with out_err=1.
  - Both saturate at all-ones with no wrap.
- Reset mid-operation: in-flight beats are discarded immediately, counters clear, and no partial result is emitted after reset release.
- Simultaneous input and output transfer with both stages full: S2 unloads, S1 moves to S2, and the new beat enters S1 in the same cycle.

Test Plan:
- WIDTH=8, op=000, a=0xFF, b=0x01, out_ready=1 -> 2 cycles later result=0x00, carry=1, zero=1, ovf=0, neg=0.
- WIDTH=8, op=000, a=0x7F, b=0x01 -> result=0x80, ovf=1, neg=1, carry=0. Then op=001, a=0x03, b=0x05 -> result=0xFE, carry=1, neg=1. Then op=010 with the same operands -> result=0x02, carry=0.
- op=111, a=0x12, b=0x34 -> result=0, err=1, zero=1. After output transfer err_count=1 and op_count incremented.
- Streaming with backpressure:
  - Send 10 back-to-back beats while out_ready toggles 1,0,0,1,….
  - Required: all 10 results arrive in order and are held stable during stalls.
  - Required: in_ready drops only when both stages are full.
  - Required: op_count=10 at the end.
- CNT_W=4: complete 20 legal operations -> op_count saturates at 15 and does not wrap.
- Assert rst_n low with both stages valid and out_ready=0 -> out_valid=0 and counters=0 immediately. After release, in_ready=1, and the first new beat appears after 2 cycles with the correct result.
